// File: rtl/output_uart.sv
// Serial transmitter fed by a small FIFO: 8N1-style frames (start, N data bits LSB first, stop),
// with a sticky overflow flag for strobes that arrive while the FIFO is full.
module output_uart #(
  parameter int unsigned N            = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N-1:0]                  data_in,
  input  logic                          load_strobe,
  input  logic                          clear_overflow,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [AW:0]   FullCnt = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LastClk = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LastBit = BW'(N - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [N-1:0]  mem_q [FIFO_DEPTH];

  logic pop, push, drop, bit_end;

  // A full FIFO still accepts a strobe when the head is leaving on the same edge.
  assign pop     = (state_q == StIdle) && (count_q != '0);
  assign push    = load_strobe && ((count_q != FullCnt) || pop);
  assign drop    = load_strobe && !push;
  assign bit_end = (cnt_q == LastClk);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    cnt_d    = '0;
    bit_d    = bit_q;
    shreg_d  = shreg_q;

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end

    if (state_q != StIdle) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (pop) begin
          shreg_d = mem_q[rd_ptr_q];
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == LastBit) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  // Outputs decode straight from reset-cleared state so reset takes effect without a clock.
  assign tx         = (state_q == StData) ? shreg_q[0] : (state_q != StStart);
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign fifo_full  = (count_q == FullCnt);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/output_uart.md
OUTPUT_UART -- requirements
Module: output_uart

Parameters
REQ-001 SHALL provide parameter N, default 8: data word width in bits, equal to the output register width.
REQ-002 SHALL provide parameter CLKS_PER_BIT, default 16: clk cycles per serial bit period, legal range 2 or more.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4: FIFO entries, a power of two, legal range 2 or more.

Interface
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  N  output register contents (output_contents).
REQ-007 load_strobe  input  1  one-cycle pulse: data_in is a new value to send.
REQ-008 clear_overflow  input  1  synchronous clear of the overflow flag.
REQ-009 tx  output  1  serial line; idle level is 1.
REQ-010 busy  output  1  high while a frame is in flight or the FIFO is not empty.
REQ-011 fifo_full  output  1  high when fifo_count equals FIFO_DEPTH.
REQ-012 fifo_count  output  log2(FIFO_DEPTH)+1  number of FIFO entries held.
REQ-013 overflow  output  1  sticky: a strobe was dropped.

Function
REQ-014 A load_strobe sampled high SHALL push data_in when fifo_count < FIFO_DEPTH, or when a pop occurs on the same edge.
REQ-015 A load_strobe that cannot push SHALL drop data_in, leave the FIFO unchanged and set overflow on that edge.
REQ-016 overflow SHALL clear on an edge where clear_overflow is high; a simultaneous drop SHALL take priority and leave overflow set.
REQ-017 The FIFO SHALL be first-in first-out; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-019 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-020 IDLE with fifo_count > 0 SHALL pop the head entry into a shift register and enter START on the same edge.
REQ-021 IDLE with the FIFO empty SHALL remain in IDLE.
REQ-022 tx SHALL be 1 in IDLE, 0 in START, shift-register bit 0 in DATA and 1 in STOP.
REQ-023 Each of START, DATA-bit and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter that resets on every state or bit change.
REQ-024 DATA SHALL send N bits LSB first, shifting right once per bit period, then enter STOP.
REQ-025 STOP SHALL return to IDLE after one bit period.
REQ-026 A frame SHALL last (N+2)*CLKS_PER_BIT cycles.
REQ-027 Back-to-back frames SHALL be separated by exactly one IDLE cycle with tx = 1.
REQ-028 Latency: for a strobe at edge k into an idle, empty block, the pop and START entry SHALL occur at edge k+1, so tx falls after edge k+1.
REQ-029 A strobe during a frame SHALL never alter the frame in flight.
REQ-030 busy SHALL equal (state != IDLE) OR (fifo_count != 0).

Reset
REQ-031 reset_n low SHALL immediately force: tx = 1, state IDLE, bit counter 0, shift register 0, pointers 0, fifo_count 0, fifo_full 0, overflow 0, busy 0.
REQ-032 A reset mid-frame SHALL abandon the frame, discard all FIFO contents and return tx to 1 without waiting for a clock edge.
REQ-033 The first push SHALL be accepted on the first rising edge after reset_n deasserts.

Verification (N=8, CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Single send: strobe 0xA5 while idle -> starting edge k+1, tx is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; 40 cycles in total; busy then falls.
REQ-035 Burst: strobes 0x01..0x05 on 5 consecutive cycles from idle -> fifo_count peaks at 4 with no overflow; frames 0x01..0x05 go out in order with one idle cycle between each.
REQ-036 Overflow: FIFO full and a frame in flight, strobe 0x06 -> 0x06 is never transmitted, overflow = 1 and fifo_count stays 4; clear_overflow -> overflow = 0 on the next edge.
REQ-037 Full plus pop: FIFO full and the FSM entering IDLE, strobe 0x77 on the pop edge -> push accepted, fifo_count stays 4, overflow stays 0, and 0x77 is sent last.
REQ-038 Priority: clear_overflow and a dropped strobe on the same edge -> overflow = 1.
REQ-039 Reset mid-frame: reset_n low during DATA bit 3 -> tx = 1 and fifo_count = 0 immediately; after release, strobe 0x3C -> a clean 40-cycle frame.
